// File: rtl/rvv_backend_retire_wb_if.sv
// ---------------------------------------------------------------------------
// rvv_backend_retire_wb_if
// Purpose : bundles the retire-stage buses: the ROB-to-retire lanes, the
//           registered VRF write port, the scalar result queue head, the
//           vxsat pulse and the trap-done handshake.
// Ports   : rd_*            ROB -> retire lanes (valid, fields) and ready back
//           rt2vrf_wr_*     registered VRF writes, one per lane
//           rt2xrf_*        scalar result FIFO head with valid/ready
//           rt2vcsr_vxsat_valid  one-cycle vxsat set pulse
//           trap_done_*     trap drain complete handshake
// The ROB2RT record is carried as per-field lane arrays (lane 0 = LSB slot).
// Encodings: rd_w_type 0 = VRF, 1 = XRF;
//            rd_vd_type per byte 0 = NOT_CHANGE, 1 = TAIL,
//            2 = BODY_INACTIVE, 3 = BODY_ACTIVE.
// Modports: master = ROB / scalar core side, slave = retire stage.
// ---------------------------------------------------------------------------
interface rvv_backend_retire_wb_if #(
    parameter int NUM_RT_UOP = 4,
    parameter int VLENB      = 16,
    parameter int XLEN       = 32
);
    logic [NUM_RT_UOP-1:0]                   rd_valid_rob2rt;
    logic [NUM_RT_UOP-1:0]                   rd_w_valid;
    logic [NUM_RT_UOP-1:0][4:0]              rd_w_index;
    logic [NUM_RT_UOP-1:0][VLENB*8-1:0]      rd_w_data;
    logic [NUM_RT_UOP-1:0]                   rd_w_type;
    logic [NUM_RT_UOP-1:0][VLENB-1:0][1:0]   rd_vd_type;
    logic [NUM_RT_UOP-1:0]                   rd_trap_flag;
    logic [NUM_RT_UOP-1:0]                   rd_vxsat;
    logic [NUM_RT_UOP-1:0]                   rd_ignore_vta;
    logic [NUM_RT_UOP-1:0]                   rd_ignore_vma;
    logic [NUM_RT_UOP-1:0]                   rd_ready_rt2rob;

    logic [NUM_RT_UOP-1:0]                   rt2vrf_wr_valid;
    logic [NUM_RT_UOP-1:0][4:0]              rt2vrf_wr_index;
    logic [NUM_RT_UOP-1:0][VLENB*8-1:0]      rt2vrf_wr_data;
    logic [NUM_RT_UOP-1:0][VLENB-1:0]        rt2vrf_wr_strobe;

    logic                                    rt2xrf_valid;
    logic [4:0]                              rt2xrf_index;
    logic [XLEN-1:0]                         rt2xrf_data;
    logic                                    rt2xrf_ready;

    logic                                    rt2vcsr_vxsat_valid;
    logic                                    trap_done_rvv2rvs;
    logic                                    trap_done_ready;

    modport master (
        output rd_valid_rob2rt, rd_w_valid, rd_w_index, rd_w_data, rd_w_type,
               rd_vd_type, rd_trap_flag, rd_vxsat, rd_ignore_vta, rd_ignore_vma,
               rt2xrf_ready, trap_done_ready,
        input  rd_ready_rt2rob, rt2vrf_wr_valid, rt2vrf_wr_index, rt2vrf_wr_data,
               rt2vrf_wr_strobe, rt2xrf_valid, rt2xrf_index, rt2xrf_data,
               rt2vcsr_vxsat_valid, trap_done_rvv2rvs
    );

    modport slave (
        input  rd_valid_rob2rt, rd_w_valid, rd_w_index, rd_w_data, rd_w_type,
               rd_vd_type, rd_trap_flag, rd_vxsat, rd_ignore_vta, rd_ignore_vma,
               rt2xrf_ready, trap_done_ready,
        output rd_ready_rt2rob, rt2vrf_wr_valid, rt2vrf_wr_index, rt2vrf_wr_data,
               rt2vrf_wr_strobe, rt2xrf_valid, rt2xrf_index, rt2xrf_data,
               rt2vcsr_vxsat_valid, trap_done_rvv2rvs
    );
endinterface

// File: rtl/rvv_backend_retire_wb.sv
// ---------------------------------------------------------------------------
// rvv_backend_retire_wb
// Purpose : retire/writeback stage behind the ROB. Accepts up to NUM_RT_UOP
//           in-order uops per cycle, issues registered byte-strobed VRF
//           writes, queues scalar results for the scalar core, pulses vxsat
//           and runs the trap drain / acknowledge handshake.
// Ports   : clk, rst_n (async, active-low)
//           bus          rvv_backend_retire_wb_if.slave (all lane/result buses)
//           o_retire_cnt accepted-lane counter, only with RETIRE_PERF_CNT_EN
// Config  : define RETIRE_PERF_CNT_EN to add the retire performance counter.
// ---------------------------------------------------------------------------
module rvv_backend_retire_wb #(
    parameter int NUM_RT_UOP = 4,
    parameter int VLENB      = 16,
    parameter int XLEN       = 32,
    parameter int XQ_DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    rvv_backend_retire_wb_if.slave   bus
`ifdef RETIRE_PERF_CNT_EN
    ,
    output logic [31:0]              o_retire_cnt
`endif
);
    localparam int PTR_W = (XQ_DEPTH > 1) ? $clog2(XQ_DEPTH) : 1;

    localparam logic       W_TYPE_XRF       = 1'b1;
    localparam logic [1:0] VD_TAIL          = 2'd1;
    localparam logic [1:0] VD_BODY_INACTIVE = 2'd2;
    localparam logic [1:0] VD_BODY_ACTIVE   = 2'd3;

    typedef enum logic [1:0] {RUN, TRAP_DRAIN, TRAP_ACK} state_t;

    state_t                              r_state;
    logic                                r_trap_done;
    logic [XQ_DEPTH-1:0][4:0]            r_xq_idx;
    logic [XQ_DEPTH-1:0][XLEN-1:0]       r_xq_data;
    logic [PTR_W-1:0]                    r_wptr;
    logic [PTR_W-1:0]                    r_rptr;
    logic [PTR_W:0]                      r_xq_cnt;
    logic [NUM_RT_UOP-1:0]               r_wr_valid;
    logic [NUM_RT_UOP-1:0][4:0]          r_wr_index;
    logic [NUM_RT_UOP-1:0][VLENB*8-1:0]  r_wr_data;
    logic [NUM_RT_UOP-1:0][VLENB-1:0]    r_wr_strobe;
    logic                                r_vxsat;

    logic [7:0]                          w_free;
    logic [7:0]                          w_cum;
    logic                                w_chain;
    logic [NUM_RT_UOP-1:0]               w_vrf_cand;
    logic [NUM_RT_UOP-1:0]               w_xrf_cand;
    logic [NUM_RT_UOP-1:0]               w_ready;
    logic [NUM_RT_UOP-1:0]               w_accept;
    logic [NUM_RT_UOP-1:0]               w_vrf_wr;
    logic [NUM_RT_UOP-1:0]               w_xrf_push;
    logic [NUM_RT_UOP-1:0][PTR_W-1:0]    w_slot;
    logic [PTR_W-1:0]                    w_wptr_nxt;
    logic [PTR_W:0]                      w_push_cnt;
    logic [NUM_RT_UOP-1:0][VLENB-1:0]    w_strobe_raw;
    logic [NUM_RT_UOP-1:0][VLENB-1:0]    w_strobe;
    logic                                w_trap_hit;
    logic                                w_vxsat_hit;
    logic                                w_pop;

    // Lane acceptance: the ready chain stops after a trap lane and wherever
    // the cumulative scalar pushes would exceed the slots free at cycle start.
    // Trap uops write nothing, so they never consume a credit.
    always_comb begin
        w_free  = 8'(XQ_DEPTH) - 8'(r_xq_cnt);
        w_cum   = '0;
        w_chain = (r_state == RUN);
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            w_vrf_cand[i] = bus.rd_valid_rob2rt[i] & bus.rd_w_valid[i] &
                            (bus.rd_w_type[i] != W_TYPE_XRF) & ~bus.rd_trap_flag[i];
            w_xrf_cand[i] = bus.rd_valid_rob2rt[i] & bus.rd_w_valid[i] &
                            (bus.rd_w_type[i] == W_TYPE_XRF) & ~bus.rd_trap_flag[i];
            w_cum         = w_cum + 8'(w_xrf_cand[i]);
            w_ready[i]    = w_chain & (w_cum <= w_free);
            w_chain       = w_ready[i] & ~(bus.rd_valid_rob2rt[i] & bus.rd_trap_flag[i]);
        end
        w_accept    = bus.rd_valid_rob2rt & w_ready;
        w_vrf_wr    = w_accept & w_vrf_cand;
        w_xrf_push  = w_accept & w_xrf_cand;
        w_trap_hit  = |(w_accept & bus.rd_trap_flag);
        w_vxsat_hit = |(w_accept & bus.rd_w_valid & bus.rd_vxsat & ~bus.rd_trap_flag);
        w_pop       = (r_xq_cnt != '0) & bus.rt2xrf_ready;
    end

    // Scalar pushes are packed into consecutive FIFO slots in lane order.
    always_comb begin
        w_wptr_nxt = r_wptr;
        w_push_cnt = '0;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            w_slot[i] = w_wptr_nxt;
            if (w_xrf_push[i]) begin
                w_wptr_nxt = w_wptr_nxt + PTR_W'(1);
                w_push_cnt = w_push_cnt + (PTR_W+1)'(1);
            end
        end
    end

    // Byte strobes from the per-byte body/tail classification, then the
    // same-cycle WAW merge: a younger lane to the same register owns every
    // byte it writes, so those bytes are removed from all older lanes.
    always_comb begin
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            for (int b = 0; b < VLENB; b++) begin
                case (bus.rd_vd_type[i][b])
                    VD_BODY_ACTIVE:   w_strobe_raw[i][b] = 1'b1;
                    VD_BODY_INACTIVE: w_strobe_raw[i][b] = bus.rd_ignore_vma[i];
                    VD_TAIL:          w_strobe_raw[i][b] = bus.rd_ignore_vta[i];
                    default:          w_strobe_raw[i][b] = 1'b0;
                endcase
            end
        end
        w_strobe = w_strobe_raw;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            for (int j = i + 1; j < NUM_RT_UOP; j++) begin
                if (w_vrf_wr[i] && w_vrf_wr[j] &&
                    (bus.rd_w_index[i] == bus.rd_w_index[j])) begin
                    w_strobe[i] = w_strobe[i] & ~w_strobe_raw[j];
                end
            end
        end
    end

    // Trap FSM: drain the scalar queue, then hold trap_done until acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_trap_done <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_trap_hit) r_state <= TRAP_DRAIN;
                end
                TRAP_DRAIN: begin
                    if (r_xq_cnt == '0) begin
                        r_state     <= TRAP_ACK;
                        r_trap_done <= 1'b1;
                    end
                end
                TRAP_ACK: begin
                    if (bus.trap_done_ready) begin
                        r_state     <= RUN;
                        r_trap_done <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= RUN;
                    r_trap_done <= 1'b0;
                end
            endcase
        end
    end

    // Scalar result FIFO; credits guarantee no push overflows a full queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xq_idx  <= '0;
            r_xq_data <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_xq_cnt  <= '0;
        end else begin
            for (int i = 0; i < NUM_RT_UOP; i++) begin
                if (w_xrf_push[i]) begin
                    r_xq_idx[w_slot[i]]  <= bus.rd_w_index[i];
                    r_xq_data[w_slot[i]] <= bus.rd_w_data[i][XLEN-1:0];
                end
            end
            r_wptr   <= w_wptr_nxt;
            r_rptr   <= r_rptr + PTR_W'(w_pop);
            r_xq_cnt <= r_xq_cnt + w_push_cnt - (PTR_W+1)'(w_pop);
        end
    end

    // VRF write port and vxsat pulse, both one cycle behind acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_valid  <= '0;
            r_wr_index  <= '0;
            r_wr_data   <= '0;
            r_wr_strobe <= '0;
            r_vxsat     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_RT_UOP; i++) begin
                r_wr_valid[i] <= w_vrf_wr[i];
                if (w_vrf_wr[i]) begin
                    r_wr_index[i]  <= bus.rd_w_index[i];
                    r_wr_data[i]   <= bus.rd_w_data[i];
                    r_wr_strobe[i] <= w_strobe[i];
                end
            end
            r_vxsat <= w_vxsat_hit;
        end
    end

`ifdef RETIRE_PERF_CNT_EN
    // Counts every accepted lane, trap uops included; wraps naturally.
    logic [31:0] r_retire_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_retire_cnt <= '0;
        else        r_retire_cnt <= r_retire_cnt + 32'($countones(w_accept));
    end
    assign o_retire_cnt = r_retire_cnt;
`endif

    // Ready is forced low while reset is held so every output reads 0.
    assign bus.rd_ready_rt2rob     = w_ready & {NUM_RT_UOP{rst_n}};
    assign bus.rt2vrf_wr_valid     = r_wr_valid;
    assign bus.rt2vrf_wr_index     = r_wr_index;
    assign bus.rt2vrf_wr_data      = r_wr_data;
    assign bus.rt2vrf_wr_strobe    = r_wr_strobe;
    assign bus.rt2xrf_valid        = (r_xq_cnt != '0);
    assign bus.rt2xrf_index        = r_xq_idx[r_rptr];
    assign bus.rt2xrf_data         = r_xq_data[r_rptr];
    assign bus.rt2vcsr_vxsat_valid = r_vxsat;
    assign bus.trap_done_rvv2rvs   = r_trap_done;
endmodule

// File: tb/tb_rvv_backend_retire_wb.sv
// ---------------------------------------------------------------------------
// tb_rvv_backend_retire_wb
// Purpose : directed testbench for rvv_backend_retire_wb. A vector table
//           covers single-cycle VRF retirement (strobes, WAW merge, vxsat);
//           hand-written sequences cover scalar FIFO credit, trap drain and
//           acknowledge, and reset in the middle of a trap handshake.
// Config  : checks o_retire_cnt when RETIRE_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_rvv_backend_retire_wb;
    localparam int N     = 4;
    localparam int VLENB = 16;
    localparam int XLEN  = 32;

    localparam logic [VLENB-1:0][1:0] VD_NC     = '0;
    localparam logic [VLENB-1:0][1:0] VD_TAIL   = {VLENB{2'd1}};
    localparam logic [VLENB-1:0][1:0] VD_INACT  = {VLENB{2'd2}};
    localparam logic [VLENB-1:0][1:0] VD_ACT    = {VLENB{2'd3}};

    typedef struct {
        logic [N-1:0]                  valid;
        logic [N-1:0]                  wv;
        logic [N-1:0]                  wtype;
        logic [N-1:0]                  vxsat;
        logic [N-1:0]                  vma;
        logic [N-1:0]                  vta;
        logic [N-1:0][4:0]             idx;
        logic [N-1:0][VLENB-1:0][1:0]  vd;
        logic [N-1:0]                  expReady;
        logic [N-1:0]                  expWrValid;
        logic [N-1:0][VLENB-1:0]       expStrobe;
        logic                          expVxsat;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    vec_t vec[8];

    always #5 clk = ~clk;

    rvv_backend_retire_wb_if #(.NUM_RT_UOP(N), .VLENB(VLENB), .XLEN(XLEN)) bus();

`ifdef RETIRE_PERF_CNT_EN
    logic [31:0] retireCnt;
    rvv_backend_retire_wb #(.NUM_RT_UOP(N), .VLENB(VLENB), .XLEN(XLEN), .XQ_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .o_retire_cnt(retireCnt));
`else
    rvv_backend_retire_wb #(.NUM_RT_UOP(N), .VLENB(VLENB), .XLEN(XLEN), .XQ_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    function automatic logic [XLEN-1:0] xData(input logic [4:0] idx);
        return {24'hC0FFEE, 3'b000, idx};
    endfunction

    function automatic logic [VLENB*8-1:0] laneData(input logic [4:0] idx);
        return {4{xData(idx)}};
    endfunction

    function automatic logic [VLENB-1:0][1:0] vdMix(input logic [VLENB-1:0] mask,
                                                    input logic [1:0] inCode,
                                                    input logic [1:0] outCode);
        logic [VLENB-1:0][1:0] r;
        for (int b = 0; b < VLENB; b++) r[b] = mask[b] ? inCode : outCode;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clearLanes();
        bus.rd_valid_rob2rt = '0;
        bus.rd_w_valid      = '0;
        bus.rd_w_index      = '0;
        bus.rd_w_data       = '0;
        bus.rd_w_type       = '0;
        bus.rd_vd_type      = '0;
        bus.rd_trap_flag    = '0;
        bus.rd_vxsat        = '0;
        bus.rd_ignore_vta   = '0;
        bus.rd_ignore_vma   = '0;
    endtask

    task automatic applyStimulus(input int i, input logic wv, input logic wtype, input logic trap,
                                 input logic vxsat, input logic [4:0] idx,
                                 input logic [VLENB-1:0][1:0] vd, input logic vma, input logic vta);
        bus.rd_valid_rob2rt[i] = 1'b1;
        bus.rd_w_valid[i]      = wv;
        bus.rd_w_type[i]       = wtype;
        bus.rd_trap_flag[i]    = trap;
        bus.rd_vxsat[i]        = vxsat;
        bus.rd_w_index[i]      = idx;
        bus.rd_w_data[i]       = laneData(idx);
        bus.rd_vd_type[i]      = vd;
        bus.rd_ignore_vma[i]   = vma;
        bus.rd_ignore_vta[i]   = vta;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Vector table: {valid, wv, wtype, vxsat, vma, vta, idx, vd, ready, wr_valid, strobe, vxsat}
        vec[0] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                   {5'd4, 5'd3, 5'd2, 5'd1}, {VD_ACT, VD_ACT, VD_ACT, VD_ACT},
                   4'b1111, 4'b1111, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 1'b0};
        vec[1] = '{4'b0111, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                   {5'd0, 5'd8, 5'd9, 5'd8}, {VD_NC, vdMix(16'h00FF, 2'd3, 2'd0), VD_ACT, VD_ACT},
                   4'b1111, 4'b0111, {16'h0000, 16'h00FF, 16'hFFFF, 16'hFF00}, 1'b0};
        vec[2] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'b0001,
                   {5'd13, 5'd12, 5'd11, 5'd10}, {VD_INACT, VD_INACT, VD_TAIL, VD_TAIL},
                   4'b1111, 4'b1111, {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF}, 1'b0};
        vec[3] = '{4'b0111, 4'b0111, 4'b0000, 4'b0100, 4'b0000, 4'b0000,
                   {5'd0, 5'd6, 5'd5, 5'd4}, {VD_ACT, VD_ACT, VD_ACT, VD_ACT},
                   4'b1111, 4'b0111, {16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 1'b1};
        vec[4] = '{4'b0111, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b0000,
                   {5'd0, 5'd5, 5'd1, 5'd2}, {VD_ACT, VD_ACT, VD_ACT, VD_ACT},
                   4'b1111, 4'b0100, {16'h0000, 16'hFFFF, 16'h0000, 16'h0000}, 1'b0};
        vec[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                   {5'd0, 5'd0, 5'd0, 5'd0}, {VD_NC, VD_NC, VD_NC, VD_NC},
                   4'b1111, 4'b0000, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1'b0};
        vec[6] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                   {5'd3, 5'd7, 5'd3, 5'd3},
                   {vdMix(16'hFF00, 2'd3, 2'd0), VD_ACT, vdMix(16'h000F, 2'd3, 2'd0), VD_ACT},
                   4'b1111, 4'b1111, {16'hFF00, 16'hFFFF, 16'h000F, 16'h00F0}, 1'b0};
        vec[7] = '{4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 4'b0000,
                   {5'd0, 5'd0, 5'd15, 5'd14},
                   {VD_NC, VD_NC, vdMix(16'h0F0F, 2'd2, 2'd1), vdMix(16'h00FF, 2'd3, 2'd1)},
                   4'b1111, 4'b0011, {16'h0000, 16'h0000, 16'h0F0F, 16'h00FF}, 1'b0};

        clearLanes();
        bus.rt2xrf_ready    = 1'b0;
        bus.trap_done_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_ready", bus.rd_ready_rt2rob, 4'b0000);
        checkOutput("rst_xrf_valid", bus.rt2xrf_valid, 1'b0);
        checkOutput("rst_trap_done", bus.trap_done_rvv2rvs, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", bus.rd_ready_rt2rob, 4'b1111);
        checkOutput("post_rst_wr_valid", bus.rt2vrf_wr_valid, 4'b0000);
        checkOutput("post_rst_vxsat", bus.rt2vcsr_vxsat_valid, 1'b0);

        // Table vectors, applied back to back
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            clearLanes();
            for (int i = 0; i < N; i++) begin
                if (vec[k].valid[i])
                    applyStimulus(i, vec[k].wv[i], vec[k].wtype[i], 1'b0, vec[k].vxsat[i],
                                  vec[k].idx[i], vec[k].vd[i], vec[k].vma[i], vec[k].vta[i]);
            end
            #1;
            checkOutput($sformatf("v%0d_ready", k), bus.rd_ready_rt2rob, vec[k].expReady);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_wr_valid", k), bus.rt2vrf_wr_valid, vec[k].expWrValid);
            checkOutput($sformatf("v%0d_vxsat", k), bus.rt2vcsr_vxsat_valid, vec[k].expVxsat);
            for (int i = 0; i < N; i++) begin
                if (vec[k].expWrValid[i]) begin
                    checkOutput($sformatf("v%0d_l%0d_strobe", k, i), bus.rt2vrf_wr_strobe[i], vec[k].expStrobe[i]);
                    checkOutput($sformatf("v%0d_l%0d_index", k, i), bus.rt2vrf_wr_index[i], vec[k].idx[i]);
                    checkOutput($sformatf("v%0d_l%0d_data", k, i), bus.rt2vrf_wr_data[i], laneData(vec[k].idx[i]));
                end
            end
        end

        // Scalar FIFO credit: three XRF lanes into a two-deep queue
        @(negedge clk);
        clearLanes();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd10, VD_NC, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd11, VD_NC, 1'b0, 1'b0);
        applyStimulus(2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd12, VD_NC, 1'b0, 1'b0);
        #1;
        checkOutput("xq_ready_3lanes", bus.rd_ready_rt2rob, 4'b0011);
        @(posedge clk);
        #1;
        checkOutput("xq_head_valid", bus.rt2xrf_valid, 1'b1);
        checkOutput("xq_head_index", bus.rt2xrf_index, 5'd10);
        checkOutput("xq_head_data", bus.rt2xrf_data, xData(5'd10));
        @(negedge clk);
        clearLanes();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd12, VD_NC, 1'b0, 1'b0);
        #1;
        checkOutput("xq_full_ready", bus.rd_ready_rt2rob, 4'b0000);
        @(posedge clk);
        #1;
        checkOutput("xq_full_hold_index", bus.rt2xrf_index, 5'd10);
        @(negedge clk);
        bus.rt2xrf_ready = 1'b1;
        #1;
        checkOutput("xq_no_pop_credit", bus.rd_ready_rt2rob, 4'b0000);
        @(posedge clk);
        #1;
        checkOutput("xq_pop1_index", bus.rt2xrf_index, 5'd11);
        @(negedge clk);
        #1;
        checkOutput("xq_ready_after_pop", bus.rd_ready_rt2rob, 4'b1111);
        @(posedge clk);
        #1;
        checkOutput("xq_pop2_index", bus.rt2xrf_index, 5'd12);
        checkOutput("xq_pop2_data", bus.rt2xrf_data, xData(5'd12));
        @(negedge clk);
        clearLanes();
        @(posedge clk);
        #1;
        checkOutput("xq_empty", bus.rt2xrf_valid, 1'b0);
        @(negedge clk);
        bus.rt2xrf_ready = 1'b0;

        // Trap in lane 1 with a scalar result queued ahead of it
        clearLanes();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd20, VD_NC, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd21, VD_ACT, 1'b0, 1'b0);
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd22, VD_ACT, 1'b0, 1'b0);
        applyStimulus(3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd23, VD_NC, 1'b0, 1'b0);
        #1;
        checkOutput("trap_ready", bus.rd_ready_rt2rob, 4'b0011);
        @(posedge clk);
        #1;
        checkOutput("trap_no_vrf", bus.rt2vrf_wr_valid, 4'b0000);
        checkOutput("trap_no_vxsat", bus.rt2vcsr_vxsat_valid, 1'b0);
        checkOutput("trap_xq_index", bus.rt2xrf_index, 5'd20);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("drain%0d_ready", c), bus.rd_ready_rt2rob, 4'b0000);
            checkOutput($sformatf("drain%0d_done", c), bus.trap_done_rvv2rvs, 1'b0);
        end
        @(negedge clk);
        bus.rt2xrf_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("drain_xq_empty", bus.rt2xrf_valid, 1'b0);
        checkOutput("drain_done_not_yet", bus.trap_done_rvv2rvs, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("ack_done", bus.trap_done_rvv2rvs, 1'b1);
        @(negedge clk);
        bus.rt2xrf_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("ack_hold%0d_done", c), bus.trap_done_rvv2rvs, 1'b1);
            checkOutput($sformatf("ack_hold%0d_ready", c), bus.rd_ready_rt2rob, 4'b0000);
        end
        @(negedge clk);
        bus.trap_done_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ack_release", bus.trap_done_rvv2rvs, 1'b0);
        @(negedge clk);
        bus.trap_done_ready = 1'b0;
        clearLanes();
        #1;
        checkOutput("run_after_trap", bus.rd_ready_rt2rob, 4'b1111);

        // Reset in the middle of TRAP_ACK
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, VD_NC, 1'b0, 1'b0);
        @(negedge clk);
        clearLanes();
        @(posedge clk);
        #1;
        checkOutput("rst_ack_done_pre", bus.trap_done_rvv2rvs, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_ack_done", bus.trap_done_rvv2rvs, 1'b0);
        checkOutput("rst_ack_ready", bus.rd_ready_rt2rob, 4'b0000);
        checkOutput("rst_ack_wr_valid", bus.rt2vrf_wr_valid, 4'b0000);
        checkOutput("rst_ack_xrf_valid", bus.rt2xrf_valid, 1'b0);
`ifdef RETIRE_PERF_CNT_EN
        checkOutput("rst_ack_retire_cnt", retireCnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, VD_ACT, 1'b0, 1'b0);
        #1;
        checkOutput("rst_run_ready", bus.rd_ready_rt2rob, 4'b1111);
        @(posedge clk);
        #1;
        checkOutput("rst_run_wr_valid", bus.rt2vrf_wr_valid, 4'b0001);
        checkOutput("rst_run_done", bus.trap_done_rvv2rvs, 1'b0);
`ifdef RETIRE_PERF_CNT_EN
        checkOutput("rst_run_retire_cnt", retireCnt, 32'd1);
`endif
        @(negedge clk);
        clearLanes();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
